ddr3_read_control: RTL and testbench

- Read-side engine for the DDR3 address/command path; drives the read request pair (rd_addr, rd_app_en) and consumes rd_app_rdy from the DDR3 address/command arbiter.
- Collects returned memory data and streams it to the readout path with ready/valid backpressure.
- Memory read data has no backpressure, so issue is credit-limited to guarantee no returned word is ever dropped.

---
 rtl/ddr3_rd_pkg.sv | 14 +
 rtl/ddr3_rd_fifo.sv | 59 +++++
 rtl/ddr3_read_control.sv | 126 ++++++++++++
 tb/tb_ddr3_read_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rd_pkg.sv
// Shared types and defaults for the DDR3 read-side engine.
package ddr3_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFinish
    } rd_state_e;

    localparam int unsigned DefAddrStep = 8;
    localparam int unsigned DefDepth    = 16;

endpackage

// File: rtl/ddr3_rd_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned read data.
module ddr3_rd_fifo #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped; the parent flags it.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ddr3_read_control.sv
// DDR3 read engine: credit-limited read issue, return buffering and ready/valid readout.
module ddr3_read_control
    import ddr3_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned CNT_W     = 23,
    parameter int unsigned ADDR_STEP = DefAddrStep,
    parameter int unsigned DEPTH     = DefDepth
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  burst_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_app_en,
    input  logic              rd_app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              rd_err
);

    localparam int unsigned CredW    = $clog2(DEPTH) + 1;
    localparam int unsigned CredSumW = CredW + 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CredW-1:0]  outstanding_q, outstanding_d;
    logic              done_q, done_d;
    logic              rd_err_q, rd_err_d;

    logic [CredW-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic [CredSumW-1:0] credits_used;
    logic                issue, ret, pop, unexpected;

    // Credits cover both in-flight reads and buffered words, so a return always has room.
    assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign rd_app_en    = (state_q == StIssue) && (remaining_q != '0) &&
                          (credits_used < CredSumW'(DEPTH));
    assign issue        = rd_app_en && rd_app_rdy;
    assign unexpected   = app_rd_data_valid && (outstanding_q == '0);
    assign ret          = app_rd_data_valid && (outstanding_q != '0);
    assign dout_valid   = !fifo_empty;
    assign pop          = dout_valid && dout_ready;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign rd_addr = addr_q;
    assign rd_err  = rd_err_q;

    ddr3_rd_fifo #(
        .Width (DATA_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (ret),
        .wdata_i (app_rd_data),
        .pop_i   (pop),
        .rdata_o (dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        done_d        = 1'b0;
        outstanding_d = outstanding_q + CredW'(issue) - CredW'(ret);
        rd_err_d      = rd_err_q || unexpected || (ret && fifo_full);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = burst_count;
                    state_d     = (burst_count != '0) ? StIssue : StFinish;
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(ADDR_STEP);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if ((outstanding_q == '0) && fifo_empty) state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            rd_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            rd_err_q      <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_ddr3_read_control.sv
// Bench for ddr3_read_control: memory model with delayed returns and a readout scoreboard.
module tb_ddr3_read_control;

    localparam int unsigned ADDR_W    = 26;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned CNT_W     = 23;
    localparam int unsigned ADDR_STEP = 8;
    localparam int unsigned DEPTH     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [CNT_W-1:0]  burst_count = '0;
    logic              busy, done, rd_app_en, dout_valid, rd_err;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_app_rdy = 1'b1;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_ready = 1'b1;

    ddr3_read_control #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP),
        .DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_addr        (start_addr),
        .burst_count       (burst_count),
        .busy              (busy),
        .done              (done),
        .rd_addr           (rd_addr),
        .rd_app_en         (rd_app_en),
        .rd_app_rdy        (rd_app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .rd_err            (rd_err)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              ret_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int cyc = 0, ret_dly = 3, n_cmp = 0, n_bad = 0;
    int accept_cnt = 0, out_cnt = 0, done_cnt = 0, en_cnt = 0, start_cyc = 0, done_lat = 0;
    logic [ADDR_W-1:0] exp_addr = '0, last_addr = '0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and scoreboard; everything sampled on the falling edge.
    always @(negedge clk) begin
        ret_t              r;
        logic [DATA_W-1:0] d;
        cyc++;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (start && !busy) begin
                exp_addr   = start_addr;
                accept_cnt = 0;
                out_cnt    = 0;
                done_cnt   = 0;
                en_cnt     = 0;
                start_cyc  = cyc;
            end
            if (rd_app_en) en_cnt++;
            if (rd_app_en && rd_app_rdy) begin
                check_eq("rd_addr", DATA_W'(rd_addr), DATA_W'(exp_addr));
                d      = {$urandom, $urandom, $urandom, $urandom};
                r.due  = cyc + ret_dly;
                r.data = d;
                ret_q.push_back(r);
                exp_q.push_back(d);
                last_addr = rd_addr;
                exp_addr  = exp_addr + ADDR_W'(ADDR_STEP);
                accept_cnt++;
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) check_eq("dout_extra", DATA_W'(exp_q.size()), DATA_W'(1));
                else check_eq("dout", dout, exp_q.pop_front());
                out_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_lat = cyc - start_cyc;
                check_eq("busy_at_done", DATA_W'(busy), '0);
            end
        end
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            app_rd_data       = r.data;
            app_rd_data_valid = 1'b1;
        end else begin
            app_rd_data       = '0;
            app_rd_data_valid = 1'b0;
        end
    end

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"},   DATA_W'(busy),       '0);
        check_eq({tag, "_done"},   DATA_W'(done),       '0);
        check_eq({tag, "_en"},     DATA_W'(rd_app_en),  '0);
        check_eq({tag, "_addr"},   DATA_W'(rd_addr),    '0);
        check_eq({tag, "_dvalid"}, DATA_W'(dout_valid), '0);
        check_eq({tag, "_err"},    DATA_W'(rd_err),     '0);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        @(posedge clk);
        #1;
        start       = 1'b1;
        start_addr  = a;
        burst_count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int tmo);
        for (int i = 0; i < tmo; i++) begin
            if (done_cnt != 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic burst of four with 3-cycle return latency.
        do_start(26'h100, 4);
        wait_done(200);
        check_eq("t1_accepts", DATA_W'(accept_cnt), DATA_W'(4));
        check_eq("t1_words",   DATA_W'(out_cnt),    DATA_W'(4));
        check_eq("t1_done",    DATA_W'(done_cnt),   DATA_W'(1));
        check_eq("t1_last",    DATA_W'(last_addr),  DATA_W'(26'h118));
        check_eq("t1_err",     DATA_W'(rd_err),     '0);

        // Zero-length burst.
        do_start(26'h200, 0);
        wait_done(50);
        check_eq("t2_en",   DATA_W'(en_cnt),   '0);
        check_eq("t2_done", DATA_W'(done_cnt), DATA_W'(1));
        check_eq("t2_lat",  DATA_W'(done_lat), DATA_W'(2));

        // Credit limit under full backpressure.
        dout_ready = 1'b0;
        do_start(26'h2000, 40);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check_eq("t3_credit_accepts", DATA_W'(accept_cnt), DATA_W'(DEPTH));
        check_eq("t3_en_low",         DATA_W'(rd_app_en),  '0);
        check_eq("t3_dvalid",         DATA_W'(dout_valid), DATA_W'(1));
        @(posedge clk);
        #1 dout_ready = 1'b1;
        wait_done(500);
        check_eq("t3_accepts", DATA_W'(accept_cnt), DATA_W'(40));
        check_eq("t3_words",   DATA_W'(out_cnt),    DATA_W'(40));
        check_eq("t3_done",    DATA_W'(done_cnt),   DATA_W'(1));
        check_eq("t3_err",     DATA_W'(rd_err),     '0);

        // Arbiter stall on the second request.
        rd_app_rdy = 1'b0;
        do_start(26'h400, 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_app_en) break;
        end
        @(posedge clk);
        #1 rd_app_rdy = 1'b1;
        @(posedge clk);
        #1 rd_app_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t4_en_hold",   DATA_W'(rd_app_en), DATA_W'(1));
            check_eq("t4_addr_hold", DATA_W'(rd_addr),   DATA_W'(26'h408));
        end
        @(posedge clk);
        #1 rd_app_rdy = 1'b1;
        wait_done(100);
        check_eq("t4_accepts", DATA_W'(accept_cnt), DATA_W'(3));
        check_eq("t4_words",   DATA_W'(out_cnt),    DATA_W'(3));
        check_eq("t4_last",    DATA_W'(last_addr),  DATA_W'(26'h410));

        // Address wrap.
        do_start(26'h3FFFFF8, 2);
        wait_done(100);
        check_eq("t5_accepts", DATA_W'(accept_cnt), DATA_W'(2));
        check_eq("t5_words",   DATA_W'(out_cnt),    DATA_W'(2));
        check_eq("t5_wrap",    DATA_W'(last_addr),  '0);

        // Reset with reads in flight, then stale returns.
        ret_dly = 10;
        do_start(26'h800, 8);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("t6_mid");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ret_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t6_drained", DATA_W'(ret_q.size()), '0);
        check_eq("t6_err",     DATA_W'(rd_err),       DATA_W'(1));
        check_eq("t6_dvalid",  DATA_W'(dout_valid),   '0);
        check_eq("t6_nodone",  DATA_W'(done_cnt),     '0);
        check_eq("t6_busy",    DATA_W'(busy),         '0);
        ret_dly = 3;
        do_start(26'h40, 3);
        wait_done(100);
        check_eq("t6_accepts", DATA_W'(accept_cnt), DATA_W'(3));
        check_eq("t6_words",   DATA_W'(out_cnt),    DATA_W'(3));
        check_eq("t6_done",    DATA_W'(done_cnt),   DATA_W'(1));
        check_eq("t6_sticky",  DATA_W'(rd_err),     DATA_W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
